river_boundary_gen: RTL and testbench

RIVER_BOUNDARY_GEN -- requirements
Module: river_boundary_gen

---
 rtl/river_boundary_gen_pkg.sv | 79 +++++++
 rtl/river_boundary_gen_lfsr16.sv | 21 ++
 rtl/river_boundary_gen.sv | 103 ++++++++++
 tb/tb_river_boundary_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/river_boundary_gen_pkg.sv
// Shared types, constants and walk arithmetic for the river boundary generator.
`timescale 1ns/1ps
package river_boundary_gen_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_EMIT, ST_GAP} state_t;

   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   localparam int HW_MIN        = 48;
   localparam int HW_MAX        = 240;
   localparam int CENTER_MARGIN = 16;
   localparam int X_MAX         = 623;
   localparam int ISLAND_MIN    = 16;
   localparam int CENTER_INIT   = 320;
   localparam int HW_INIT       = 128;

   typedef struct packed {
      logic [9:0] center;
      logic [9:0] hw;
      logic [9:0] island;
      logic [5:0] seg;
   } walk_t;

   localparam walk_t WALK_RESET = '{center: 10'd320, hw: 10'd128, island: 10'd0, seg: 6'd0};

   // Galois right shift: feed the dropped LSB back through the mask.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
   endfunction

   function automatic logic signed [11:0] wide(input logic [9:0] v);
      return $signed({2'b00, v});
   endfunction

   // Random step of {-2,0,0,+2} selected by a 2-bit LFSR slice.
   function automatic logic signed [11:0] nudge(input logic [9:0] v, input logic [1:0] idx);
      logic signed [11:0] d;
      case (idx)
         2'd0:    d = -12'sd2;
         2'd3:    d = 12'sd2;
         default: d = 12'sd0;
      endcase
      return wide(v) + d;
   endfunction

   // Saturate in signed 12-bit so a step below zero never wraps.
   function automatic logic [9:0] clamp10(input logic signed [11:0] x,
                                          input logic signed [11:0] lo,
                                          input logic signed [11:0] hi);
      logic signed [11:0] r;
      r = x;
      if (x < lo)      r = lo;
      else if (x > hi) r = hi;
      return r[9:0];
   endfunction

   // One random-walk step. Island != 0 doubles as the dual-river mode flag.
   function automatic walk_t walk_step(input walk_t w, input logic [15:0] rnd, input int min_chan);
      walk_t n;
      n.hw     = clamp10(nudge(w.hw, rnd[3:2]), 12'(HW_MIN), 12'(HW_MAX));
      n.center = clamp10(nudge(w.center, rnd[1:0]), wide(n.hw) + 12'(CENTER_MARGIN),
                         12'(X_MAX) - wide(n.hw));
      n.island = w.island;
      if (w.island != '0)
         n.island = clamp10(nudge(w.island, rnd[5:4]), 12'(ISLAND_MIN), wide(n.hw) - 12'(min_chan));
      n.seg = w.seg + 6'd1;
      if (w.seg == 6'd63 && rnd[15])
         n.island = (w.island != '0) ? 10'd0 : 10'(ISLAND_MIN);
      return n;
   endfunction

   function automatic logic [39:0] row_map(input walk_t w);
      if (w.island == '0)
         return {w.center - w.hw, w.center + w.hw, 20'd0};
      return {w.center - w.hw, w.center - w.island, w.center + w.island, w.center + w.hw};
   endfunction

endpackage

// File: rtl/river_boundary_gen_lfsr16.sv
// 16-bit Galois LFSR; a seed load beats an advance in the same cycle.
`timescale 1ns/1ps
module river_lfsr16
   import river_boundary_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] value
);

   // Load (zero seed maps to the default so the LFSR never locks up), else step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        value <= LFSR_SEED;
      else if (load)    value <= (seed == 16'h0000) ? LFSR_SEED : seed;
      else if (advance) value <= lfsr_next(value);
   end

endmodule

// File: rtl/river_boundary_gen.sv
// Generates river bank boundary rows by a clamped random walk, a burst per frame.
`timescale 1ns/1ps
module river_boundary_gen
   import river_boundary_gen_pkg::*;
#(
   parameter int GAP      = 2,
   parameter int MIN_CHAN = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_start,
   input  logic [2:0]  speed,
   input  logic        seed_load,
   input  logic [15:0] seed,
   input  logic        ovr_clear,
   output logic        row_valid,
   output logic [39:0] row_data,
   output logic        busy,
   output logic        overrun
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   state_t        state, state_n;
   logic [2:0]    pending;
   logic [GW-1:0] gap_cnt;
   logic          gap_done, go;
   walk_t         walk, walk_n;
   logic [15:0]   lfsr_val;

   assign go       = frame_start && enable && (speed != 3'd0);
   assign gap_done = (gap_cnt == GW'(GAP - 1));

   // The walk consumes the LFSR value held during GEN; the register steps at the same edge.
   assign walk_n = walk_step(walk, lfsr_val, MIN_CHAN);

   river_lfsr16 u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (seed_load),
      .seed    (seed),
      .advance (state == ST_GEN),
      .value   (lfsr_val)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   // Next state and state-decoded outputs; a started row always runs to the end of its GAP.
   always_comb begin
      state_n   = state;
      row_valid = 1'b0;
      busy      = (state != ST_IDLE);
      case (state)
         ST_IDLE: if (go) state_n = ST_GEN;
         ST_GEN:  state_n = ST_EMIT;
         ST_EMIT: begin
            row_valid = 1'b1;
            state_n   = ST_GAP;
         end
         ST_GAP:  if (gap_done) state_n = (pending != 3'd0 && enable) ? ST_GEN : ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Rows left in this burst; a frame_start while busy leaves it untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                      pending <= '0;
      else if (state == ST_IDLE && go)                pending <= speed;
      else if (state == ST_EMIT)                      pending <= pending - 3'd1;
      else if (state == ST_GAP && gap_done && !enable) pending <= '0;
   end

   // Counts the idle cycles after each row.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 gap_cnt <= '0;
      else if (state == ST_GAP)  gap_cnt <= gap_cnt + GW'(1);
      else                       gap_cnt <= '0;
   end

   // Sticky overrun; a new set event outranks a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    overrun <= 1'b0;
      else if (frame_start && busy) overrun <= 1'b1;
      else if (ovr_clear)           overrun <= 1'b0;
   end

   // Walk state and the registered row both update only as GEN completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         walk     <= WALK_RESET;
         row_data <= row_map(WALK_RESET);
      end else if (state == ST_GEN) begin
         walk     <= walk_n;
         row_data <= row_map(walk_n);
      end
   end

endmodule

// File: tb/tb_river_boundary_gen.sv
// Self-checking bench: vector table for burst timing, hand sequences for corners,
// and an integer reference model scoring every emitted row.
`timescale 1ns/1ps
module tb_river_boundary_gen;
   import river_boundary_gen_pkg::*;

   localparam int GAP      = 2;
   localparam int MIN_CHAN = 32;

   logic        clk = 1'b0;
   logic        reset, enable, frame_start, seed_load, ovr_clear;
   logic [2:0]  speed;
   logic [15:0] seed;
   logic        row_valid, busy, overrun;
   logic [39:0] row_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   river_boundary_gen #(.GAP(GAP), .MIN_CHAN(MIN_CHAN)) dut (
      .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
      .speed(speed), .seed_load(seed_load), .seed(seed), .ovr_clear(ovr_clear),
      .row_valid(row_valid), .row_data(row_data), .busy(busy), .overrun(overrun)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (plain integers) ----------------
   typedef struct { int lfsr; int c; int hw; int is; int seg; } mstate_t;

   function automatic int clampi(int x, int lo, int hi);
      if (x < lo) return lo;
      if (x > hi) return hi;
      return x;
   endfunction

   function automatic int dlt(int i);
      return (i == 0) ? -2 : (i == 3) ? 2 : 0;
   endfunction

   function automatic mstate_t mreset();
      mstate_t s;
      s.lfsr = int'(LFSR_SEED); s.c = CENTER_INIT; s.hw = HW_INIT; s.is = 0; s.seg = 0;
      return s;
   endfunction

   function automatic mstate_t mstep(mstate_t s);
      mstate_t n;
      int l;
      l    = s.lfsr;
      n.hw = clampi(s.hw + dlt((l >> 2) & 3), HW_MIN, HW_MAX);
      n.c  = clampi(s.c + dlt(l & 3), n.hw + CENTER_MARGIN, X_MAX - n.hw);
      n.is = (s.is != 0) ? clampi(s.is + dlt((l >> 4) & 3), ISLAND_MIN, n.hw - MIN_CHAN) : 0;
      n.seg = (s.seg + 1) % 64;
      if (s.seg == 63 && ((l >> 15) & 1) == 1) n.is = (s.is != 0) ? 0 : ISLAND_MIN;
      n.lfsr = ((l & 1) == 1) ? ((l >> 1) ^ int'(LFSR_MASK)) : (l >> 1);
      return n;
   endfunction

   function automatic logic [39:0] mrow(mstate_t s);
      if (s.is == 0) return {10'(s.c - s.hw), 10'(s.c + s.hw), 20'd0};
      return {10'(s.c - s.hw), 10'(s.c - s.is), 10'(s.c + s.is), 10'(s.c + s.hw)};
   endfunction

   mstate_t m;
   int rows_seen = 0, dual_rows = 0;
   int b1, b2, b3, b4;
   bit ok;

   // Row monitor: every row_valid advances the model and checks data and geometry.
   always @(negedge clk) begin
      if (reset === 1'b0 && row_valid === 1'b1) begin
         m = mstep(m);
         chk("row_data", row_data, mrow(m));
         rows_seen++;
         b1 = int'(row_data[39:30]); b2 = int'(row_data[29:20]);
         b3 = int'(row_data[19:10]); b4 = int'(row_data[9:0]);
         if (b3 == 0 && b4 == 0)
            ok = b1 >= 16 && b2 <= X_MAX && (b2 - b1) >= 2*HW_MIN && (b2 - b1) <= 2*HW_MAX;
         else begin
            ok = b1 < b2 && b2 < b3 && b3 < b4 && (b3 - b2) >= 2*ISLAND_MIN &&
                 (b2 - b1) >= MIN_CHAN && b1 >= 16 && b4 <= X_MAX &&
                 (b4 - b1) >= 2*HW_MIN && (b4 - b1) <= 2*HW_MAX;
            dual_rows++;
         end
         chk("clamps", ok, 1);
      end
   end

   // ---------------- stimulus helpers ----------------
   int rv_cyc[$];
   int busy_cnt;

   task automatic do_reset();
      reset = 1'b1; m = mreset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic load_seed(input logic [15:0] s);
      seed = s; seed_load = 1'b1;
      @(posedge clk); #1 seed_load = 1'b0;
      m.lfsr = (s == 16'h0) ? int'(LFSR_SEED) : int'(s);
   endtask

   // act: 1 = extra frame_start, 2 = drop enable, 3 = frame_start with ovr_clear
   task automatic run_frame(input int spd, input int act_cyc, input int act, input int ncyc);
      rv_cyc.delete(); busy_cnt = 0;
      speed = 3'(spd); frame_start = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         if (c == act_cyc) begin
            if (act == 1 || act == 3) frame_start = 1'b1;
            if (act == 3) ovr_clear = 1'b1;
            if (act == 2) enable = 1'b0;
         end
         @(negedge clk);
         if (row_valid) rv_cyc.push_back(c);
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         frame_start = 1'b0; ovr_clear = 1'b0;
      end
   endtask

   task automatic run_rows(input int n);
      int target;
      target = rows_seen + n;
      for (int b = 0; b < 2000 && rows_seen < target; b++) begin
         speed = 3'd7; frame_start = 1'b1;
         @(posedge clk); #1 frame_start = 1'b0;
         for (int k = 0; k < 40 && busy; k++) begin
            @(posedge clk); #1;
         end
         if (busy) begin
            chk("burst_timeout", busy, 0);
            return;
         end
      end
      chk("rows_generated", rows_seen >= target, 1);
   endtask

   typedef struct {
      int spd; bit en; int act_cyc; int act; int exp_rows; int exp_busy; bit exp_ovr;
   } vec_t;
   vec_t vecs[$];

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, found, base;
      mstate_t s;

      vecs.push_back('{3, 1'b1, -1, 0, 3, 12, 1'b0});
      vecs.push_back('{0, 1'b1, -1, 0, 0,  0, 1'b0});
      vecs.push_back('{1, 1'b1, -1, 0, 1,  4, 1'b0});
      vecs.push_back('{7, 1'b1, -1, 0, 7, 28, 1'b0});
      vecs.push_back('{3, 1'b0, -1, 0, 0,  0, 1'b0});
      vecs.push_back('{4, 1'b1,  3, 1, 4, 16, 1'b1});
      vecs.push_back('{5, 1'b1,  3, 2, 1,  4, 1'b0});
      vecs.push_back('{5, 1'b1,  5, 2, 2,  8, 1'b0});
      vecs.push_back('{1, 1'b1,  1, 3, 1,  4, 1'b1});

      reset = 1'b1; enable = 1'b0; frame_start = 1'b0; speed = 3'd0;
      seed_load = 1'b0; seed = 16'h0; ovr_clear = 1'b0;
      m = mreset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_row_valid", row_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_row_data", row_data, {10'd192, 10'd448, 20'd0});
      chk("rst_lfsr", dut.u_lfsr.value, 16'hACE1);
      reset = 1'b0;
      @(posedge clk); #1;

      // Burst timing table
      foreach (vecs[i]) begin
         enable = vecs[i].en;
         run_frame(vecs[i].spd, vecs[i].act_cyc, vecs[i].act, 40);
         chk($sformatf("v%0d_rows", i), rv_cyc.size(), vecs[i].exp_rows);
         foreach (rv_cyc[j])
            if (j < vecs[i].exp_rows) chk($sformatf("v%0d_row%0d_cycle", i, j), rv_cyc[j], 2 + j*(GAP+2));
         chk($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_busy);
         chk($sformatf("v%0d_overrun", i), overrun, vecs[i].exp_ovr);
         enable = 1'b1;
         if (vecs[i].exp_ovr) begin
            ovr_clear = 1'b1;
            @(posedge clk); #1 ovr_clear = 1'b0;
            chk($sformatf("v%0d_ovr_clear", i), overrun, 0);
         end
      end

      // Seed handling: zero maps to default, explicit seed loads as-is
      load_seed(16'h0000);
      chk("seed0_lfsr", dut.u_lfsr.value, 16'hACE1);
      load_seed(16'h1234);
      chk("seed_lfsr", dut.u_lfsr.value, 16'h1234);

      // seed_load during GEN wins over the advance
      seed = 16'h5555; speed = 3'd1; frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0; seed_load = 1'b1;
      @(posedge clk); #1 seed_load = 1'b0;
      chk("seed_in_gen_lfsr", dut.u_lfsr.value, 16'h5555);
      @(posedge clk); #1 m.lfsr = 'h5555;
      repeat (3) @(posedge clk);
      #1 chk("seed_in_gen_idle", busy, 0);

      // Long run from seed 0x1234 after reset
      do_reset();
      load_seed(16'h1234);
      run_rows(10000);

      // Pick a seed whose first seg wrap turns on the island, then run 500 rows
      do_reset();
      found = 0;
      for (int sd = 1; sd < 1000 && found == 0; sd++) begin
         s = mreset(); s.lfsr = sd;
         for (int r = 0; r < 64; r++) s = mstep(s);
         if (s.is != 0) found = sd;
      end
      chk("dual_seed_found", found != 0, 1);
      load_seed(16'(found));
      base = dual_rows;
      run_rows(500);
      chk("dual_rows_seen", (dual_rows - base) >= 64, 1);

      // Reset during EMIT
      speed = 3'd3; frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      @(posedge clk); #1;
      chk("emit_before_reset", row_valid, 1);
      #1 reset = 1'b1; m = mreset();
      #1;
      chk("reset_row_valid", row_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_overrun", overrun, 0);
      chk("reset_row_data", row_data, {10'd192, 10'd448, 20'd0});
      chk("reset_lfsr", dut.u_lfsr.value, 16'hACE1);
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b0;
      cnt = 0;
      repeat (16) begin
         @(negedge clk);
         if (row_valid) cnt++;
      end
      chk("no_rows_after_reset", cnt, 0);
      chk("idle_after_reset", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
